bombe_scan_ctrl: RTL and testbench

Sequencer for the bombe's three-rotor search. Steps a left/middle/right ASCII rotor position triple through all 17,576 settings AAA..ZZZ as an odometer, and pulses `load` so the downstream ASCII position registers capture each setting. It then waits a fixed settle window for the crib checker and stops on a match. It sits between the top-level control (start/resume/abort buttons) and the rotor-position registers and checker.

---
 rtl/bombe_scan_ctrl_pkg.sv | 18 +
 rtl/bombe_scan_ctrl_rotor_odometer.sv | 59 +++++
 rtl/bombe_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_bombe_scan_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bombe_scan_ctrl_pkg.sv
// Shared constants and state encoding for the bombe rotor scan sequencer.
package bombe_scan_ctrl_pkg;

    localparam logic [7:0]  CHAR_A       = 8'h41;
    localparam logic [7:0]  CHAR_Z       = 8'h5A;
    localparam int          NUM_SETTINGS = 17576;
    localparam logic [14:0] LAST_INDEX   = 15'(NUM_SETTINGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_STEP,
        ST_FOUND,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/bombe_scan_ctrl_rotor_odometer.sv
// Three-letter ASCII odometer (right is least significant) with a binary
// setting index kept in step with the letters.
module rotor_odometer
    import bombe_scan_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    output logic [7:0]  left,
    output logic [7:0]  middle,
    output logic [7:0]  right,
    output logic [14:0] index,
    output logic        at_zzz
);

    // carry[0] is the step request; carry[n] enters rotor n (0=right, 2=left)
    logic [2:0]  carry;
    logic [14:0] index_reg;

    assign carry[0] = step;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rotor
            logic [7:0] pos_reg;

            if (gi < 2) begin : g_carry
                assign carry[gi+1] = carry[gi] && (pos_reg == CHAR_Z);
            end

            // Each rotor advances when carried into, wrapping Z back to A
            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    pos_reg <= CHAR_A;
                end else if (carry[gi]) begin
                    pos_reg <= (pos_reg == CHAR_Z) ? CHAR_A : pos_reg + 8'h01;
                end
            end
        end
    endgenerate

    // Setting number advances with every odometer step
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            index_reg <= '0;
        end else if (step) begin
            index_reg <= index_reg + 15'd1;
        end
    end

    assign right  = g_rotor[0].pos_reg;
    assign middle = g_rotor[1].pos_reg;
    assign left   = g_rotor[2].pos_reg;
    assign index  = index_reg;
    assign at_zzz = (g_rotor[0].pos_reg == CHAR_Z) &&
                    (g_rotor[1].pos_reg == CHAR_Z) &&
                    (g_rotor[2].pos_reg == CHAR_Z);

endmodule

// File: rtl/bombe_scan_ctrl.sv
// Bombe three-rotor scan sequencer: loads each setting AAA..ZZZ, waits the
// checker settle window, and stops on a match until resumed or aborted.
module bombe_scan_ctrl
    import bombe_scan_ctrl_pkg::*;
#(
    parameter int CHECK_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        resume,
    input  logic        abort,
    input  logic        match,
    output logic [7:0]  left,
    output logic [7:0]  middle,
    output logic [7:0]  right,
    output logic        load,
    output logic        busy,
    output logic        found,
    output logic        done,
    output logic [14:0] index
);

    localparam logic [3:0] WAIT_INIT = 4'(CHECK_CYCLES - 1);

    scan_state_t state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        load_reg, busy_reg, found_reg, done_reg;
    logic        odo_clear, odo_step, at_zzz;

    rotor_odometer u_odometer (
        .clock  (clock),
        .reset  (reset),
        .clear  (odo_clear),
        .step   (odo_step),
        .left   (left),
        .middle (middle),
        .right  (right),
        .index  (index),
        .at_zzz (at_zzz)
    );

    // State, wait counter and status flags; flags decode the next state so
    // they line up with the state register without a combinational path
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            load_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            found_reg    <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            load_reg     <= (state_next == ST_LOAD);
            busy_reg     <= (state_next == ST_LOAD) || (state_next == ST_WAIT) ||
                            (state_next == ST_STEP);
            found_reg    <= (state_next == ST_FOUND);
            done_reg     <= (state_next == ST_DONE);
        end
    end

    // Next-state, wait counter and odometer control; abort overrides all
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        odo_clear     = 1'b0;
        odo_step      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    odo_clear  = 1'b1;
                end
            end
            ST_LOAD: begin
                state_next    = ST_WAIT;
                wait_cnt_next = WAIT_INIT;
            end
            ST_WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    if (match) begin
                        state_next = ST_FOUND;
                    end else if (at_zzz) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_STEP;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_STEP: begin
                odo_step   = 1'b1;
                state_next = ST_LOAD;
            end
            ST_FOUND: begin
                if (resume) begin
                    state_next = at_zzz ? ST_DONE : ST_STEP;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    odo_clear  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort && (state_reg != ST_IDLE)) begin
            state_next    = ST_IDLE;
            wait_cnt_next = '0;
            odo_clear     = 1'b1;
            odo_step      = 1'b0;
        end
    end

    assign load  = load_reg;
    assign busy  = busy_reg;
    assign found = found_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_bombe_scan_ctrl.sv
// Scoreboard bench for bombe_scan_ctrl: a main instance (CHECK_CYCLES=4) for
// randomized scans with hits/abort/reset, and two CHECK_CYCLES=1 instances
// for the full no-hit scan and the hit-at-ZZZ case.
module tb_bombe_scan_ctrl;

    localparam int CC   = 4;
    localparam int NSET = 17576;

    typedef struct {
        int setting;
        int cycle;
    } ev_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // main instance
    logic reset, start, resume, abort, match;
    logic [7:0] left, middle, right;
    logic [14:0] index;
    logic load, busy, found, done;

    // full-scan instance
    logic reset_f, start_f;
    logic [7:0] left_f, middle_f, right_f;
    logic [14:0] index_f;
    logic load_f, busy_f, found_f, done_f;
    logic zero_f = 1'b0;

    // hit-at-ZZZ instance
    logic reset_z, start_z, resume_z, abort_z, match_z;
    logic [7:0] left_z, middle_z, right_z;
    logic [14:0] index_z;
    logic load_z, busy_z, found_z, done_z;

    bombe_scan_ctrl #(.CHECK_CYCLES(CC)) dut (
        .clock(clock), .reset(reset), .start(start), .resume(resume),
        .abort(abort), .match(match), .left(left), .middle(middle),
        .right(right), .load(load), .busy(busy), .found(found),
        .done(done), .index(index)
    );

    bombe_scan_ctrl #(.CHECK_CYCLES(1)) dut_f (
        .clock(clock), .reset(reset_f), .start(start_f), .resume(zero_f),
        .abort(zero_f), .match(zero_f), .left(left_f), .middle(middle_f),
        .right(right_f), .load(load_f), .busy(busy_f), .found(found_f),
        .done(done_f), .index(index_f)
    );

    bombe_scan_ctrl #(.CHECK_CYCLES(1)) dut_z (
        .clock(clock), .reset(reset_z), .start(start_z), .resume(resume_z),
        .abort(abort_z), .match(match_z), .left(left_z), .middle(middle_z),
        .right(right_z), .load(load_z), .busy(busy_z), .found(found_z),
        .done(done_z), .index(index_z)
    );

    ev_t load_q[$];
    ev_t found_q[$];
    ev_t mon_e;
    logic found_d = 1'b0;
    int nload_f = 0;
    int nload_z = 0;

    // reference: setting number to ASCII letters by plain base-26 arithmetic
    function automatic logic [23:0] letters_of(input int n);
        logic [7:0] l, m, r;
        l = 8'(65 + n / 676);
        m = 8'(65 + (n / 26) % 26);
        r = 8'(65 + n % 26);
        return {l, m, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic rand_busy();
        match  = 1'($urandom_range(0, 1));
        start  = 1'($urandom_range(0, 1));
        resume = 1'($urandom_range(0, 1));
    endtask

    // monitor: every load pulse and every found rising edge pops the scoreboard
    always @(negedge clock) begin
        if (load === 1'b1) begin
            if (load_q.size() == 0) begin
                chk("unexpected_load", 64'(1), 64'(0));
            end else begin
                mon_e = load_q.pop_front();
                chk("load_cycle", 64'(mon_e.cycle), 64'(cyc));
                chk("load_setting", 64'({left, middle, right, index, busy}),
                    64'({letters_of(mon_e.setting), 15'(mon_e.setting), 1'b1}));
                $display("load   setting=%0d pos=%s idx=%0d cycle=%0d",
                         mon_e.setting, {left, middle, right}, index, cyc);
            end
        end
        if (found === 1'b1 && found_d !== 1'b1) begin
            if (found_q.size() == 0) begin
                chk("unexpected_found", 64'(1), 64'(0));
            end else begin
                mon_e = found_q.pop_front();
                chk("found_cycle", 64'(mon_e.cycle), 64'(cyc));
                chk("found_setting", 64'({left, middle, right, index}),
                    64'({letters_of(mon_e.setting), 15'(mon_e.setting)}));
                $display("found  setting=%0d pos=%s idx=%0d cycle=%0d",
                         mon_e.setting, {left, middle, right}, index, cyc);
            end
        end
        found_d <= found;
    end

    // full-scan monitor: the n-th load must present setting n
    always @(negedge clock) begin
        if (load_f === 1'b1) begin
            chk("full_load", 64'({left_f, middle_f, right_f, index_f}),
                64'({letters_of(nload_f), 15'(nload_f)}));
            nload_f <= nload_f + 1;
        end
        if (load_z === 1'b1) nload_z <= nload_z + 1;
    end

    // one scan of the main instance from AAA; mode 0 ends with abort+match at
    // last_s, mode 1 makes last_s a hit and ends with reset+resume in FOUND
    task automatic run_main_scan(input int last_s, input int hit_a, input int hit_b, input int mode);
        int L;
        bit hit;
        start = 1'b1;
        L = cyc + 1;
        load_q.push_back('{setting: 0, cycle: L});
        tick();
        start = 1'b0;
        for (int s = 0; s <= last_s; s++) begin
            while (cyc < L + CC) begin
                rand_busy();
                tick();
            end
            if (s == last_s && mode == 0) begin
                match = 1'b1; abort = 1'b1; start = 1'b0; resume = 1'b0;
                tick();
                abort = 1'b0; match = 1'b0;
                chk("abort_idle", 64'({load, busy, found, done, left, middle, right, index}),
                    64'({4'b0000, 24'h414141, 15'd0}));
                $display("abort  at setting=%0d cycle=%0d", s, cyc);
                repeat (3) tick();
                return;
            end
            hit = (s == hit_a) || (s == hit_b) || (mode == 1 && s == last_s);
            match  = hit;
            start  = 1'($urandom_range(0, 1));
            resume = 1'($urandom_range(0, 1));
            if (hit) found_q.push_back('{setting: s, cycle: L + CC + 1});
            tick();
            resume = 1'b0;
            start  = 1'($urandom_range(0, 1));
            match  = 1'($urandom_range(0, 1));
            if (!hit) begin
                L = L + CC + 2;
                load_q.push_back('{setting: s + 1, cycle: L});
                tick();
            end else begin
                repeat ($urandom_range(0, 3)) tick();
                chk("found_hold", 64'({found, busy, left, middle, right, index}),
                    64'({2'b10, letters_of(s), 15'(s)}));
                resume = 1'b1;
                if (mode == 1 && s == last_s) begin
                    reset = 1'b1;
                    tick();
                    resume = 1'b0; start = 1'b0; match = 1'b0;
                    chk("reset_in_found", 64'({load, busy, found, done, left, middle, right, index}),
                        64'({4'b0000, 24'h414141, 15'd0}));
                    $display("reset  in found setting=%0d cycle=%0d", s, cyc);
                    tick();
                    reset = 1'b0;
                    repeat (3) tick();
                    return;
                end
                L = cyc + 2;
                load_q.push_back('{setting: s + 1, cycle: L});
                tick();
                rand_busy();
                resume = 1'b0;
                tick();
            end
        end
    endtask

    task automatic main_seq();
        reset = 1'b1; start = 1'b0; resume = 1'b0; abort = 1'b0; match = 1'b0;
        tick(); tick();
        chk("reset_values", 64'({load, busy, found, done, left, middle, right, index}),
            64'({4'b0000, 24'h414141, 15'd0}));
        reset = 1'b0;
        tick();
        repeat (5) begin
            resume = 1'($urandom_range(0, 1));
            match  = 1'($urandom_range(0, 1));
            tick();
        end
        resume = 1'b0; match = 1'b0;
        run_main_scan(60, 51, $urandom_range(3, 40), 0);
        run_main_scan($urandom_range(8, 20), $urandom_range(1, 6), -1, 1);
        run_main_scan(3, -1, -1, 0);
        for (int i = 0; i < 3; i++) begin
            run_main_scan($urandom_range(5, 15), $urandom_range(0, 4), -1, $urandom_range(0, 1));
        end
    endtask

    task automatic full_seq();
        int lf;
        reset_f = 1'b1; start_f = 1'b0;
        tick(); tick();
        reset_f = 1'b0;
        tick();
        start_f = 1'b1;
        lf = cyc + 1;
        tick();
        start_f = 1'b0;
        wait_cyc(lf + NSET * 3 - 2);
        chk("full_not_done_early", 64'(done_f), 64'(0));
        tick();
        chk("full_done", 64'({done_f, busy_f, found_f, left_f, middle_f, right_f, index_f}),
            64'({3'b100, 24'h5A5A5A, 15'd17575}));
        chk("full_load_count", 64'(nload_f), 64'(NSET));
        $display("full   done cycle=%0d loads=%0d", cyc, nload_f);
        repeat (3) tick();
        chk("full_done_hold", 64'({done_f, load_f}), 64'({1'b1, 1'b0}));
        chk("full_load_count_hold", 64'(nload_f), 64'(NSET));
    endtask

    task automatic zzz_seq();
        int lz;
        reset_z = 1'b1; start_z = 1'b0; resume_z = 1'b0; abort_z = 1'b0; match_z = 1'b0;
        tick(); tick();
        reset_z = 1'b0;
        tick();
        start_z = 1'b1;
        lz = cyc + 1;
        tick();
        start_z = 1'b0;
        wait_cyc(lz + 3 * (NSET - 1) + 1);
        match_z = 1'b1;
        tick();
        match_z = 1'b0;
        chk("zzz_found", 64'({found_z, busy_z, done_z, left_z, middle_z, right_z, index_z}),
            64'({3'b100, 24'h5A5A5A, 15'd17575}));
        chk("zzz_load_count", 64'(nload_z), 64'(NSET));
        $display("zzz    found cycle=%0d", cyc);
        resume_z = 1'b1;
        tick();
        resume_z = 1'b0;
        chk("zzz_resume_done", 64'({done_z, found_z, busy_z, load_z}), 64'({4'b1000}));
        repeat (4) tick();
        chk("zzz_no_more_loads", 64'(nload_z), 64'(NSET));
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        chk("zzz_restart", 64'({load_z, busy_z, done_z, left_z, middle_z, right_z, index_z}),
            64'({3'b110, 24'h414141, 15'd0}));
        $display("zzz    restart cycle=%0d", cyc);
        abort_z = 1'b1;
        tick();
        abort_z = 1'b0;
        chk("zzz_abort", 64'({load_z, busy_z, left_z, middle_z, right_z}),
            64'({2'b00, 24'h414141}));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; resume = 1'b0; abort = 1'b0; match = 1'b0;
        reset_f = 1'b1; start_f = 1'b0;
        reset_z = 1'b1; start_z = 1'b0; resume_z = 1'b0; abort_z = 1'b0; match_z = 1'b0;
        fork
            main_seq();
            full_seq();
            zzz_seq();
        join
        repeat (2) tick();
        chk("load_queue_empty", 64'(load_q.size()), 64'(0));
        chk("found_queue_empty", 64'(found_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
